// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, control-code type and decoder FSM states.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    CTRL_00 = 2'b00,
    CTRL_01 = 2'b01,
    CTRL_10 = 2'b10,
    CTRL_11 = 2'b11
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'b00,
    ST_SLIP_WAIT = 2'b01,
    ST_LOCKED    = 2'b10
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tmds_dec_char.sv
// Combinational 10b character classification (control token vs data) and 10b-to-8b data decode.
module tmds_dec_char
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       tok,
  output ctrl_t      code,
  output logic [7:0] data
);

  logic [8:0] q;

  always_comb begin
    tok  = 1'b1;
    code = CTRL_00;
    case (word)
      TOK_C00: code = CTRL_00;
      TOK_C01: code = CTRL_01;
      TOK_C10: code = CTRL_10;
      TOK_C11: code = CTRL_11;
      default: tok = 1'b0;
    endcase

    // Bit 9 flags a DC-balance inversion of the low byte; bit 8 selects XOR vs XNOR chaining.
    q = word[9] ? {word[8], ~word[7:0]} : word[8:0];
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_dec.sv
// TMDS channel decoder: character alignment FSM with bitslip requests and a 2-stage decode pipeline.
module tmds_dec
  import tmds_pkg::*;
#(
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 4,
  parameter int TOKEN_MIN      = 8,
  parameter int LOCK_LOSS      = 8192
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] tmds_word_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  localparam int CMAX = max2(max2(SEARCH_TIMEOUT, LOCK_LOSS), max2(SLIP_WAIT, TOKEN_MIN));
  localparam int CW   = $clog2(CMAX + 1);

  logic       c_tok;
  ctrl_t      c_code;
  logic [7:0] c_data;

  tmds_dec_char u_char (
    .word (tmds_word_i),
    .tok  (c_tok),
    .code (c_code),
    .data (c_data)
  );

  // Stage 1 carries the character already classified and decoded.
  logic       s1_tok;
  ctrl_t      s1_code;
  logic [7:0] s1_data;

  state_t          state_q, state_d;
  logic [CW-1:0]   miss_q, miss_d;  // SEARCH misses; consecutive non-tokens while LOCKED
  logic [CW-1:0]   run_q, run_d;    // SEARCH token run; settle count in SLIP_WAIT
  logic            slip_q, slip_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    run_d   = run_q;
    slip_d  = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (s1_tok) begin
          miss_d = '0;
          if (run_q == CW'(TOKEN_MIN - 1)) begin
            run_d   = '0;
            state_d = ST_LOCKED;
          end else begin
            run_d = sat_inc(run_q);
          end
        end else begin
          run_d = '0;
          if (miss_q == CW'(SEARCH_TIMEOUT - 1)) begin
            miss_d  = '0;
            slip_d  = 1'b1;
            state_d = ST_SLIP_WAIT;
          end else begin
            miss_d = sat_inc(miss_q);
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (run_q == CW'(SLIP_WAIT - 1)) begin
          run_d   = '0;
          state_d = ST_SEARCH;
        end else begin
          run_d = sat_inc(run_q);
        end
      end
      ST_LOCKED: begin
        if (s1_tok) begin
          miss_d = '0;
        end else if (miss_q == CW'(LOCK_LOSS - 1)) begin
          miss_d  = '0;
          state_d = ST_SEARCH;
        end else begin
          miss_d = sat_inc(miss_q);
        end
      end
      default: begin
        miss_d  = '0;
        run_d   = '0;
        state_d = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_tok  <= 1'b0;
      s1_code <= CTRL_00;
      s1_data <= '0;
      state_q <= ST_SEARCH;
      miss_q  <= '0;
      run_q   <= '0;
      slip_q  <= 1'b0;
      de_o    <= 1'b0;
      ctrl_o  <= '0;
      data_o  <= '0;
    end else begin
      s1_tok  <= c_tok;
      s1_code <= c_code;
      s1_data <= c_data;
      state_q <= state_d;
      miss_q  <= miss_d;
      run_q   <= run_d;
      slip_q  <= slip_d;
      // Outputs stay quiet until aligned; ctrl holds through data periods.
      if (state_q != ST_LOCKED) begin
        de_o   <= 1'b0;
        ctrl_o <= '0;
        data_o <= '0;
      end else if (s1_tok) begin
        de_o   <= 1'b0;
        ctrl_o <= s1_code;
        data_o <= '0;
      end else begin
        de_o   <= 1'b1;
        data_o <= s1_data;
      end
    end
  end

  assign bitslip_o = slip_q;
  assign locked_o  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tmds_dec.sv
// Directed and table-driven bench for tmds_dec, with a bitslip-honouring deserializer model and reference encoder.
module tb_tmds_dec;

  localparam int P_ST = 16;
  localparam int P_SW = 4;
  localparam int P_TM = 8;
  localparam int P_LL = 32;
  localparam logic [9:0] T00 = 10'h354;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tmds_word = '0;
  logic       bitslip, locked, de;
  logic [1:0] ctrl;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int slip_cnt = 0;
  logic slip_prev = 1'b0;

  always #5 clk = ~clk;

  tmds_dec #(
    .SEARCH_TIMEOUT (P_ST),
    .SLIP_WAIT      (P_SW),
    .TOKEN_MIN      (P_TM),
    .LOCK_LOSS      (P_LL)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .tmds_word_i (tmds_word),
    .bitslip_o   (bitslip),
    .locked_o    (locked),
    .de_o        (de),
    .ctrl_o      (ctrl),
    .data_o      (data)
  );

  typedef struct {
    logic [9:0] w;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive a word, advance to the next falling edge, watch bitslip.
  task automatic tick(input logic [9:0] w);
    tmds_word = w;
    @(negedge clk);
    if (bitslip) begin
      slip_cnt++;
      check("slip_not_back_to_back", {31'd0, slip_prev}, 32'd0);
    end
    slip_prev = bitslip;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tmds_word = '0;
    @(negedge clk);
    @(negedge clk);
    slip_prev = 1'b0;
    rst_n = 1'b1;
  endtask

  // Eight tokens from SEARCH: still unlocked after the 8th clock, locked after the 9th.
  task automatic lock_seq(input string tag);
    int base;
    base = slip_cnt;
    for (int i = 0; i < 8; i++) tick(T00);
    check({tag, "_unlocked_at_8"}, {31'd0, locked}, 32'd0);
    tick(T00);
    check({tag, "_locked_at_9"}, {31'd0, locked}, 32'd1);
    check({tag, "_no_slip"}, slip_cnt - base, 32'd0);
  endtask

  function automatic logic [9:0] rotr(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} >> n;
    return t[9:0];
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
    logic [8:0] qm;
    logic       xnr;
    int         n1;
    n1  = $countones(d);
    xnr = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xnr ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xnr;
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  initial begin
    int         n, off, npulse, lock_at;
    int         pulses[4];
    logic [9:0] toks[4];
    logic [10:0] expq[$];
    logic [10:0] e;
    logic [1:0] exp_ctrl;
    logic [7:0] b;
    logic [1:0] k;

    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

    vecs[0]  = '{10'h100, 1'b1, 2'b00, 8'h00};
    vecs[1]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
    vecs[2]  = '{10'h1FF, 1'b1, 2'b01, 8'h01};
    vecs[3]  = '{10'h0FF, 1'b1, 2'b01, 8'hFF};
    vecs[4]  = '{10'h154, 1'b0, 2'b10, 8'h00};
    vecs[5]  = '{10'h000, 1'b1, 2'b10, 8'hFE};
    vecs[6]  = '{10'h300, 1'b1, 2'b10, 8'h01};
    vecs[7]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
    vecs[8]  = '{10'h200, 1'b1, 2'b11, 8'hFF};
    vecs[9]  = '{10'h155, 1'b1, 2'b11, 8'hFF};
    vecs[10] = '{10'h101, 1'b1, 2'b11, 8'h03};
    vecs[11] = '{10'h0AA, 1'b1, 2'b11, 8'h00};
    vecs[12] = '{10'h354, 1'b0, 2'b00, 8'h00};

    // Reset state
    @(negedge clk);
    check("reset_outputs", {19'd0, bitslip, locked, de, ctrl, data}, 32'd0);
    do_reset();

    // Plain lock from reset
    lock_seq("lock");

    // Table of characters while locked, 2-cycle latency
    for (int i = 0; i < 15; i++) begin
      if (i >= 2) check($sformatf("vec%0d", i - 2), {21'd0, de, ctrl, data},
                        {21'd0, vecs[i-2].de, vecs[i-2].ctrl, vecs[i-2].data});
      tick((i < 13) ? vecs[i].w : T00);
    end

    // Lock loss after LOCK_LOSS consecutive non-tokens
    for (int i = 0; i < P_LL; i++) tick(10'h100);
    check("loss_still_locked_at_32", {31'd0, locked}, 32'd1);
    tick(10'h100);
    check("loss_unlocked_at_33", {31'd0, locked}, 32'd0);
    check("loss_last_data_de", {31'd0, de}, 32'd1);
    tick(10'h100);
    check("loss_de_forced_0", {23'd0, de, data}, 32'd0);

    // Reset while in SLIP_WAIT
    do_reset();
    n = 0;
    while (!bitslip && n < 40) begin
      tick(10'h100);
      n++;
    end
    check("first_slip_cycle", n, P_ST);
    rst_n = 1'b0;
    #1;
    check("reset_in_slip_wait", {19'd0, bitslip, locked, de, ctrl, data}, 32'd0);
    @(negedge clk);
    slip_prev = 1'b0;
    rst_n = 1'b1;
    lock_seq("relock");

    // Stream rotated by 3 bits with a deserializer that honours bitslip
    do_reset();
    off = 3; npulse = 0; lock_at = -1;
    for (int c = 1; c <= 200 && lock_at < 0; c++) begin
      tick(rotr(T00, off));
      if (bitslip) begin
        if (npulse < 4) pulses[npulse] = c;
        npulse++;
        off = (off + 9) % 10;
      end
      if (locked) lock_at = c;
    end
    check("rot_pulse_count", npulse, 3);
    check("rot_first_pulse", pulses[0], P_ST);
    check("rot_spacing_1", pulses[1] - pulses[0], P_ST + P_SW);
    check("rot_spacing_2", pulses[2] - pulses[1], P_ST + P_SW);
    check("rot_lock_cycle", lock_at, pulses[2] + P_SW + P_TM);

    // Reference-encoded random data with periodic control tokens
    exp_ctrl = 2'b00;
    for (int i = 0; i < 10722; i++) begin
      if (i >= 2) begin
        e = expq.pop_front();
        check($sformatf("rand%0d", i - 2), {21'd0, de, ctrl, data}, {21'd0, e});
      end
      if (i % 16 == 15) begin
        k = 2'($urandom_range(0, 3));
        exp_ctrl = k;
        expq.push_back({1'b0, k, 8'h00});
        tick(toks[k]);
      end else begin
        b = 8'($urandom_range(0, 255));
        expq.push_back({1'b1, exp_ctrl, b});
        tick(enc(b, 1'($urandom_range(0, 1))));
      end
    end
    check("rand_still_locked", {31'd0, locked}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_dec.md
TMDS_DEC -- requirements
Module: tmds_dec

Interface
REQ-001 Parameter SEARCH_TIMEOUT, default 2048: consecutive non-token cycles in SEARCH before a bitslip request.
REQ-002 Parameter SLIP_WAIT, default 4: cycles ignored after each bitslip pulse while the deserializer settles.
REQ-003 Parameter TOKEN_MIN, default 8: consecutive control tokens required to declare lock.
REQ-004 Parameter LOCK_LOSS, default 8192: consecutive non-token cycles in LOCKED that drop lock.
REQ-005 clk_i  input  1  pixel clock; the only clock.
REQ-006 rst_n_i  input  1  asynchronous active-low reset.
REQ-007 tmds_word_i  input  10  parallel TMDS character from the deserializer; bit 0 is transmitted first.
REQ-008 bitslip_o  output  1  one-cycle pulse requesting a 1-bit word rotation from the deserializer.
REQ-009 locked_o  output  1  character alignment achieved.
REQ-010 de_o  output  1  decoded data-enable; 1 = data_o valid, 0 = control period.
REQ-011 ctrl_o  output  2  decoded C1:C0 control bits.
REQ-012 data_o  output  8  decoded pixel byte.

Function
REQ-013 Token map on tmds_word_i[9:0]: 0x354 -> ctrl 00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11; every other value is a data word.
REQ-014 Data decode: q = word[9] ? {word[8], ~word[7:0]} : word[8:0]; d[0] = q[0]; for i = 1..7, d[i] = q[i]^q[i-1] if q[8]=1, else ~(q[i]^q[i-1]).
REQ-015 Pipeline: stage 1 registers tmds_word_i plus the token flag and code; stage 2 registers de_o/ctrl_o/data_o, giving a fixed 2-cycle latency.
REQ-016 States are SEARCH, SLIP_WAIT and LOCKED; reset enters SEARCH.
REQ-017 SEARCH: miss counter increments on each stage-1 non-token and clears on a token; run counter increments on each token and clears on a non-token.
REQ-018 SEARCH: miss counter reaching SEARCH_TIMEOUT-1 on a non-token -> bitslip_o=1 for exactly that cycle, both counters clear, go to SLIP_WAIT.
REQ-019 SEARCH: run counter reaching TOKEN_MIN-1 on a token -> go to LOCKED; locked_o=1 from the next cycle.
REQ-020 SLIP_WAIT: a counter counts SLIP_WAIT cycles and then returns to SEARCH; tokens seen in SLIP_WAIT are ignored, and no bitslip is issued in SLIP_WAIT.
REQ-021 LOCKED: token -> de_o=0, ctrl_o=code, data_o=0; non-token -> de_o=1, ctrl_o holds its last value, data_o=decoded byte.
REQ-022 LOCKED: consecutive non-tokens reaching LOCK_LOSS -> go to SEARCH with counters cleared; locked_o=0 the next cycle.
REQ-023 While not LOCKED: de_o=0, ctrl_o=0, data_o=0, including words still draining from stage 1.
REQ-024 Counters saturate and never wrap.
REQ-025 Simultaneous events: a bitslip and a lock decision cannot occur in the same cycle; the token or non-token flag selects exactly one branch.
REQ-026 bitslip_o is never high on two consecutive cycles.

Reset
REQ-027 rst_n_i low asynchronously clears all state: state=SEARCH, counters=0, pipeline=0, bitslip_o=0, locked_o=0, de_o=0, ctrl_o=0, data_o=0.
REQ-028 Reset asserted mid-operation, including during SLIP_WAIT or LOCKED, takes effect immediately; after release the block restarts the search from SEARCH.

Structure
REQ-029 A shared package tmds_pkg holds the four token constants, the ctrl code type and the state enum, and is shared with the encoder side.
REQ-030 One sub-module, tmds_dec_char, does the combinational 10b-to-8b decode and token classification; the FSM and pipeline live in tmds_dec.

Verification (SEARCH_TIMEOUT=16, SLIP_WAIT=4, TOKEN_MIN=8, LOCK_LOSS=32)
REQ-031 Send 8 x 0x354 after reset -> locked_o=1 on the cycle after the 8th token; no bitslip_o pulse.
REQ-032 While locked, send 0x100 then 0x0AB -> 2 cycles later de_o=1 with data_o=0x00, then de_o=0 with ctrl_o=01.
REQ-033 Send the token stream rotated by 3 bits, with a model deserializer honouring bitslip_o -> exactly 3 (mod 10) pulses, each spaced 16+4 cycles, then lock.
REQ-034 While locked, send 32 consecutive 0x100 -> locked_o drops and de_o is forced to 0.
REQ-035 Assert rst_n_i during SLIP_WAIT -> all outputs 0 immediately; after release, 8 tokens relock with no spurious bitslip.
REQ-036 Send random legal 8b bytes through a reference encoder -> data_o matches the source byte with 2-cycle latency for 10,000 words.
